// File: rtl/fetch_if.sv
// Fetch-stage bundle: the instruction-memory address/data pair, downstream control inputs and the IF/ID outputs.
// The master modport is the fetch stage. The slave modport is the memory/decode side.
interface fetch_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       imem_addr;
    logic [15:0]      imem_instr;
    logic             stall;
    logic             redirect_valid;
    logic [7:0]       redirect_target;
    logic             halt_req;
    logic             resume;
    logic [15:0]      ifid_instr;
    logic [7:0]       ifid_pc;
    logic             ifid_valid;
    logic             halted;
    logic [CNT_W-1:0] fetch_count;

    modport master (
        output imem_addr, ifid_instr, ifid_pc, ifid_valid, halted, fetch_count,
        input  imem_instr, stall, redirect_valid, redirect_target, halt_req, resume
    );

    modport slave (
        input  imem_addr, ifid_instr, ifid_pc, ifid_valid, halted, fetch_count,
        output imem_instr, stall, redirect_valid, redirect_target, halt_req, resume
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fills the IF/ID register and runs the BOOT/RUN/HALT control FSM.
//  state | meaning
//  BOOT  | single bubble cycle after reset release, nothing captured
//  RUN   | normal fetch; redirect > stall > halt_req > fetch
//  HALT  | pc held, IF/ID invalid; leaves on resume
module fetch_stage #(
    parameter logic [7:0]  RESET_PC = 8'h00,
    parameter logic [15:0] NOP_WORD = 16'h0000,
    parameter int          CNT_W    = 16
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       pc;
    logic [15:0]      ifid_instr;
    logic [7:0]       ifid_pc;
    logic             ifid_valid;
    logic [CNT_W-1:0] fetch_count;

    logic do_redirect;
    logic do_hold;
    logic do_fetch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (!bus.redirect_valid && !bus.stall && bus.halt_req) begin
                    state_nxt = HALT;
                end
            end
            HALT: begin
                if (bus.resume) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_comb begin
        do_redirect = 1'b0;
        do_hold     = 1'b0;
        do_fetch    = 1'b0;
        if (state == RUN) begin
            do_redirect = bus.redirect_valid;
            do_hold     = !bus.redirect_valid && bus.stall;
            do_fetch    = !bus.redirect_valid && !bus.stall && !bus.halt_req;
        end
    end

    // Outside a fetch or stall the IF/ID slot is always invalid; only a redirect also scrubs the word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            ifid_instr  <= NOP_WORD;
            ifid_pc     <= 8'h00;
            ifid_valid  <= 1'b0;
            fetch_count <= '0;
        end else if (do_redirect) begin
            pc         <= bus.redirect_target;
            ifid_instr <= NOP_WORD;
            ifid_valid <= 1'b0;
        end else if (do_fetch) begin
            ifid_instr <= bus.imem_instr;
            ifid_pc    <= pc;
            ifid_valid <= 1'b1;
            pc         <= pc + 8'd1;
            if (fetch_count != '1) begin
                fetch_count <= fetch_count + 1'b1;
            end
        end else if (!do_hold) begin
            ifid_valid <= 1'b0;
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.ifid_instr  = ifid_instr;
    assign bus.ifid_pc     = ifid_pc;
    assign bus.ifid_valid  = ifid_valid;
    assign bus.halted      = (state == HALT);
    assign bus.fetch_count = fetch_count;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes expected IF/ID words, a negedge monitor pops and compares.
// A second, narrow-counter instance free-runs to exercise fetch_count saturation.
module tb_fetch_stage;
    logic clk;
    logic rst;

    fetch_if #(.CNT_W(16)) bus ();
    fetch_if #(.CNT_W(3))  bus2 ();

    fetch_stage #(.RESET_PC(8'h00), .NOP_WORD(16'h0000), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    fetch_stage #(.RESET_PC(8'h00), .NOP_WORD(16'h0000), .CNT_W(3)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2.master)
    );

    logic [15:0] mem [256];
    assign bus.imem_instr  = mem[bus.imem_addr];
    assign bus2.imem_instr = {8'h00, bus2.imem_addr};

    typedef struct {
        logic [15:0] instr;
        logic [7:0]  pc;
    } exp_t;

    exp_t        sb[$];
    int          n_total = 0;
    int          n_pass  = 0;
    logic [15:0] last_count = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [15:0] instr, input logic [7:0] pc);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        sb.push_back(e);
    endtask

    // A new IF/ID delivery is recognised by the delivered-instruction count moving.
    always @(negedge clk) begin
        if (!rst && bus.ifid_valid && bus.fetch_count != last_count) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected: got word %0h pc %0h with nothing expected", bus.ifid_instr, bus.ifid_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_instr", {16'h0, bus.ifid_instr}, {16'h0, e.instr});
                chk("mon_pc", {24'h0, bus.ifid_pc}, {24'h0, e.pc});
            end
        end
        last_count = bus.fetch_count;
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]   = 16'h1044;
        mem[1]   = 16'h1081;
        mem[2]   = 16'h00ca;
        mem[3]   = 16'h0319;
        mem[4]   = 16'h098a;
        mem[5]   = 16'h0daa;
        mem[255] = 16'habcd;

        rst                  = 1'b1;
        bus.stall            = 1'b0;
        bus.redirect_valid   = 1'b0;
        bus.redirect_target  = 8'h00;
        bus.halt_req         = 1'b0;
        bus.resume           = 1'b0;
        bus2.stall           = 1'b0;
        bus2.redirect_valid  = 1'b0;
        bus2.redirect_target = 8'h00;
        bus2.halt_req        = 1'b0;
        bus2.resume          = 1'b0;

        #3;
        chk("rst_valid", {31'h0, bus.ifid_valid}, 32'h0);
        chk("rst_instr", {16'h0, bus.ifid_instr}, 32'h0);
        chk("rst_pc", {24'h0, bus.ifid_pc}, 32'h0);
        chk("rst_halted", {31'h0, bus.halted}, 32'h0);
        chk("rst_count", {16'h0, bus.fetch_count}, 32'h0);
        chk("rst_addr", {24'h0, bus.imem_addr}, 32'h0);

        // Reset then run
        tick();
        rst = 1'b0;
        tick();
        chk("boot_valid", {31'h0, bus.ifid_valid}, 32'h0);
        chk("boot_addr", {24'h0, bus.imem_addr}, 32'h0);
        expect_word(16'h1044, 8'h00);
        expect_word(16'h1081, 8'h01);
        expect_word(16'h00ca, 8'h02);
        tick();
        chk("run_valid", {31'h0, bus.ifid_valid}, 32'h1);
        tick();
        tick();
        chk("run_count", {16'h0, bus.fetch_count}, 32'd3);
        chk("run_addr", {24'h0, bus.imem_addr}, 32'h3);

        // Stall; a halt_req under stall must not halt
        expect_word(16'h0319, 8'h03);
        tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus.halt_req = 1'b1;
            tick();
            chk("stall_instr", {16'h0, bus.ifid_instr}, 32'h0319);
            chk("stall_pc", {24'h0, bus.ifid_pc}, 32'h3);
            chk("stall_valid", {31'h0, bus.ifid_valid}, 32'h1);
            chk("stall_addr", {24'h0, bus.imem_addr}, 32'h4);
            chk("stall_count", {16'h0, bus.fetch_count}, 32'd4);
        end
        chk("stall_nohalt", {31'h0, bus.halted}, 32'h0);
        bus.halt_req = 1'b0;
        bus.stall    = 1'b0;
        expect_word(16'h098a, 8'h04);
        tick();
        chk("unstall_count", {16'h0, bus.fetch_count}, 32'd5);

        // Redirect overrides stall
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 8'h02;
        bus.stall           = 1'b1;
        tick();
        chk("redir_valid", {31'h0, bus.ifid_valid}, 32'h0);
        chk("redir_instr", {16'h0, bus.ifid_instr}, 32'h0);
        chk("redir_addr", {24'h0, bus.imem_addr}, 32'h2);
        chk("redir_count", {16'h0, bus.fetch_count}, 32'd5);
        bus.redirect_valid = 1'b0;
        bus.stall          = 1'b0;
        expect_word(16'h00ca, 8'h02);
        expect_word(16'h0319, 8'h03);
        expect_word(16'h098a, 8'h04);
        tick();
        tick();
        tick();
        chk("post_redir_count", {16'h0, bus.fetch_count}, 32'd8);

        // Halt / resume at pc=5; halt_req held in HALT is ignored
        bus.halt_req = 1'b1;
        tick();
        chk("halt_halted", {31'h0, bus.halted}, 32'h1);
        chk("halt_valid", {31'h0, bus.ifid_valid}, 32'h0);
        chk("halt_addr", {24'h0, bus.imem_addr}, 32'h5);
        tick();
        bus.halt_req = 1'b0;
        tick();
        chk("halt_hold_halted", {31'h0, bus.halted}, 32'h1);
        chk("halt_hold_addr", {24'h0, bus.imem_addr}, 32'h5);
        chk("halt_hold_count", {16'h0, bus.fetch_count}, 32'd8);
        bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        chk("resume_halted", {31'h0, bus.halted}, 32'h0);
        chk("resume_valid", {31'h0, bus.ifid_valid}, 32'h0);
        chk("resume_addr", {24'h0, bus.imem_addr}, 32'h5);
        expect_word(16'h0daa, 8'h05);
        tick();
        chk("resume_count", {16'h0, bus.fetch_count}, 32'd9);

        // Redirect to FF with a simultaneous halt_req: halt is dropped
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 8'hFF;
        bus.halt_req        = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        bus.halt_req       = 1'b0;
        chk("drop_halt", {31'h0, bus.halted}, 32'h0);
        chk("wrap_addr_ff", {24'h0, bus.imem_addr}, 32'hFF);
        expect_word(16'habcd, 8'hFF);
        tick();
        chk("wrap_addr_00", {24'h0, bus.imem_addr}, 32'h00);
        expect_word(16'h1044, 8'h00);
        tick();
        chk("wrap_addr_01", {24'h0, bus.imem_addr}, 32'h01);
        chk("wrap_count", {16'h0, bus.fetch_count}, 32'd11);

        // Narrow counter instance has free-run long enough to saturate
        chk("sat_count", {29'h0, bus2.fetch_count}, 32'd7);
        chk("sat_valid", {31'h0, bus2.ifid_valid}, 32'h1);
        tick();
        chk("sat_count_hold", {29'h0, bus2.fetch_count}, 32'd7);

        // Async reset mid-cycle
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'h0, bus.ifid_valid}, 32'h0);
        chk("arst_instr", {16'h0, bus.ifid_instr}, 32'h0);
        chk("arst_pc", {24'h0, bus.ifid_pc}, 32'h0);
        chk("arst_count", {16'h0, bus.fetch_count}, 32'h0);
        chk("arst_addr", {24'h0, bus.imem_addr}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("reboot_valid", {31'h0, bus.ifid_valid}, 32'h0);
        expect_word(16'h1044, 8'h00);
        tick();
        chk("reboot_count", {16'h0, bus.fetch_count}, 32'd1);

        #10;
        chk("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
